mem_access_ctrl: RTL and testbench

//  MEM-stage load/store controller. Sits directly upstream of the load-extension

---
 rtl/mem_access_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : MEM-stage load/store controller. Checks alignment and address
//            range, builds byte enables and lane-replicated store data, runs a
//            ready-handshake bus transaction while stalling the pipeline, and
//            returns the raw read word, byte offset and extension op for the
//            downstream load-extension stage.
// Ports    : clk, reset                  - clock, synchronous active-high reset
//            req_valid/we/op/addr/wdata  - access request from the MEM stage
//            stall                       - hold MEM and earlier stages
//            exc_adel / exc_ades         - load / store address fault
//            bus_req/we/addr/be/wdata    - registered bus request fields
//            bus_ready / bus_rdata       - slave completion and read data
//            resp_valid/rdata/a/op       - one-cycle completion pulse + data
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_a,
    output logic [2:0]  resp_op
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_next;

    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;
    logic [1:0]  r_a;
    logic [2:0]  r_op;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic [1:0]  r_resp_a;
    logic [2:0]  r_resp_op;

    logic        w_is_word;
    logic        w_is_byte;
    logic        w_is_half;
    logic        w_bad_op;
    logic        w_misalign;
    logic        w_fault;
    logic        w_idle;
    logic        w_accept;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    // Access decode and fault detection
    assign w_is_word  = (req_op == 3'b000);
    assign w_is_byte  = (req_op == 3'b001) || (req_op == 3'b010);
    assign w_is_half  = (req_op == 3'b011) || (req_op == 3'b100);
    assign w_bad_op   = (req_op > 3'b100);
    assign w_misalign = (w_is_word && (req_addr[1:0] != 2'b00)) ||
                        (w_is_half && req_addr[0]);
    assign w_fault    = w_bad_op || w_misalign || (req_addr >= ADDR_LIMIT);

    assign w_idle   = (r_state == c_IDLE);
    assign w_accept = w_idle && req_valid && !w_fault;

    assign exc_adel = w_idle && req_valid && !req_we && w_fault;
    assign exc_ades = w_idle && req_valid &&  req_we && w_fault;

    // Byte enables (loads always read the full word) and store data replicated
    // across every lane the access width could land in.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = req_wdata;
        if (w_is_byte) begin
            w_wdata = {4{req_wdata[7:0]}};
            if (req_we) begin
                w_be = 4'b0001 << req_addr[1:0];
            end
        end else if (w_is_half) begin
            w_wdata = {2{req_wdata[15:0]}};
            if (req_we) begin
                w_be = req_addr[1] ? 4'b1100 : 4'b0011;
            end
        end
    end

    // Next state and stall
    always_comb begin
        w_next = r_state;
        stall  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    stall  = 1'b1;
                    w_next = c_BUSY;
                end
            end
            c_BUSY: begin
                stall = 1'b1;
                if (bus_ready) begin
                    w_next = c_RESP;
                end
            end
            c_RESP: begin
                // Pipeline advances at this edge; req_valid still shows the
                // finished instruction, so it is not looked at here.
                w_next = c_IDLE;
            end
            default: begin
                w_next = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_bus_req    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_addr   <= 32'd0;
            r_bus_be     <= 4'd0;
            r_bus_wdata  <= 32'd0;
            r_a          <= 2'd0;
            r_op         <= 3'd0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_a     <= 2'd0;
            r_resp_op    <= 3'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= req_we;
                        r_bus_addr  <= {req_addr[31:2], 2'b00};
                        r_bus_be    <= w_be;
                        r_bus_wdata <= w_wdata;
                        r_a         <= req_addr[1:0];
                        r_op        <= req_op;
                    end
                end
                c_BUSY: begin
                    if (bus_ready) begin
                        r_bus_req    <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= r_bus_we ? 32'd0 : bus_rdata;
                        r_resp_a     <= r_a;
                        r_resp_op    <= r_op;
                    end
                end
                c_RESP: begin
                    r_resp_valid <= 1'b0;
                end
                default: begin
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus_req    = r_bus_req;
    assign bus_we     = r_bus_we;
    assign bus_addr   = r_bus_addr;
    assign bus_be     = r_bus_be;
    assign bus_wdata  = r_bus_wdata;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_a     = r_resp_a;
    assign resp_op    = r_resp_op;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Self-checking bench for mem_access_ctrl. A transaction-level
//            model predicts the outputs each cycle; directed accesses add
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam logic [31:0] c_LIMIT = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = 32'd0;
    logic        stall, exc_adel, exc_ades;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_a;
    logic [2:0]  resp_op;

    mem_access_ctrl #(.ADDR_LIMIT(c_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .exc_adel(exc_adel), .exc_ades(exc_ades),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_a(resp_a), .resp_op(resp_op)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- reference rules ----------------
    function automatic int f_size(input logic [2:0] op);
        if (op == 3'd0) return 4;
        if (op <= 3'd2) return 1;
        return 2;
    endfunction

    function automatic bit f_fault(input logic [2:0] op, input logic [31:0] addr);
        if (op > 3'd4) return 1'b1;
        if (addr >= c_LIMIT) return 1'b1;
        return (int'(addr[1:0]) % f_size(op)) != 0;
    endfunction

    function automatic logic [3:0] f_be(input logic we, input logic [2:0] op, input logic [31:0] addr);
        int v;
        if (!we) return 4'hF;
        v = ((1 << f_size(op)) - 1) << int'(addr[1:0]);
        return v[3:0];
    endfunction

    function automatic logic [31:0] f_wdata(input logic [2:0] op, input logic [31:0] wd);
        logic [31:0] r;
        int sz;
        sz = f_size(op);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
        return r;
    endfunction

    // ---------------- transaction model ----------------
    // m_busy: a transaction is on the bus; m_resp: its response is being shown.
    bit          started = 1'b0;
    bit          m_busy = 1'b0, m_resp = 1'b0;
    logic        m_we = 1'b0;
    logic [31:0] m_addr = 32'd0, m_wd = 32'd0, m_rd = 32'd0;
    logic [3:0]  m_be = 4'd0;
    logic [1:0]  m_a = 2'd0, m_ra = 2'd0;
    logic [2:0]  m_op = 3'd0, m_rop = 3'd0;

    always @(posedge clk) begin
        if (reset) begin
            started = 1'b1;
            m_busy = 1'b0; m_resp = 1'b0; m_we = 1'b0;
            m_addr = 32'd0; m_wd = 32'd0; m_be = 4'd0;
            m_rd = 32'd0; m_ra = 2'd0; m_rop = 3'd0;
        end else if (m_resp) begin
            m_resp = 1'b0;
        end else if (m_busy) begin
            if (bus_ready) begin
                m_busy = 1'b0;
                m_resp = 1'b1;
                m_rd   = m_we ? 32'd0 : bus_rdata;
                m_ra   = m_a;
                m_rop  = m_op;
            end
        end else if (req_valid && !f_fault(req_op, req_addr)) begin
            m_busy = 1'b1;
            m_we   = req_we;
            m_addr = {req_addr[31:2], 2'b00};
            m_be   = f_be(req_we, req_op, req_addr);
            m_wd   = f_wdata(req_op, req_wdata);
            m_a    = req_addr[1:0];
            m_op   = req_op;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            bit idle, flt;
            idle = !m_busy && !m_resp;
            flt  = f_fault(req_op, req_addr);
            chk("m_stall", stall, m_busy || (idle && req_valid && !flt));
            chk("m_adel", exc_adel, idle && req_valid && !req_we && flt);
            chk("m_ades", exc_ades, idle && req_valid && req_we && flt);
            chk("m_bus_req", bus_req, m_busy);
            chk("m_bus_we", bus_we, m_we);
            chk("m_bus_addr", bus_addr, m_addr);
            chk("m_bus_be", bus_be, m_be);
            chk("m_bus_wdata", bus_wdata, m_wd);
            chk("m_resp_valid", resp_valid, m_resp);
            if (m_resp) begin
                chk("m_resp_rdata", resp_rdata, m_rd);
                chk("m_resp_a", resp_a, m_ra);
                chk("m_resp_op", resp_op, m_rop);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    int          stalls, resps;
    logic [3:0]  s_be;
    logic [31:0] s_wd, s_rd;
    logic        s_we, s_busreq, s_adel, s_ades, s_first_stall;
    logic [1:0]  s_a;
    logic [2:0]  s_op;

    // Presents one access as the pipeline would (held while stalled) and
    // plays a slave that asserts ready after `waits` busy cycles.
    task automatic access(input logic we, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input int waits, input logic [31:0] rd);
        int nbusy;
        bit done;
        req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wd;
        bus_rdata = rd;
        stalls = 0; resps = 0; s_busreq = 1'b0; nbusy = 0; done = 1'b0;
        s_be = 4'd0; s_wd = 32'd0; s_we = 1'b0; s_rd = 32'hxxxx_xxxx;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                s_adel = exc_adel; s_ades = exc_ades; s_first_stall = stall;
            end
            if (stall) stalls++;
            if (resp_valid) begin
                resps++; s_rd = resp_rdata; s_a = resp_a; s_op = resp_op;
            end
            if (bus_req) begin
                if (!s_busreq) begin
                    s_busreq = 1'b1; s_be = bus_be; s_wd = bus_wdata; s_we = bus_we;
                end
                bus_ready = (nbusy == waits);
                nbusy++;
            end else begin
                bus_ready = 1'b0;
            end
            if (!stall) done = 1'b1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0; bus_ready = 1'b0;
        if (!done) chk("access_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_stall", stall, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: lw, zero-wait slave
        access(1'b0, 3'b000, 32'h0000_0010, 32'd0, 0, 32'hDEAD_BEEF);
        chk("t1_be", s_be, 4'b1111);
        chk("t1_stalls", stalls, 2);
        chk("t1_resps", resps, 1);
        chk("t1_rdata", s_rd, 32'hDEAD_BEEF);
        chk("t1_a", s_a, 2'b00);
        chk("t1_op", s_op, 3'b000);

        // 2: sb / sh lane replication
        access(1'b1, 3'b001, 32'h0000_0103, 32'h0000_00A5, 0, 32'h5555_5555);
        chk("t2_sb_be", s_be, 4'b1000);
        chk("t2_sb_wd", s_wd, 32'hA5A5_A5A5);
        chk("t2_sb_we", s_we, 1'b1);
        chk("t2_sb_rdata", s_rd, 32'd0);
        access(1'b1, 3'b011, 32'h0000_0102, 32'h0000_1234, 0, 32'd0);
        chk("t2_sh_be", s_be, 4'b1100);
        chk("t2_sh_wd", s_wd, 32'h1234_1234);

        // 3: faults
        access(1'b0, 3'b100, 32'h0000_0011, 32'd0, 0, 32'd0);
        chk("t3_lh_adel", s_adel, 1'b1);
        chk("t3_lh_stalls", stalls, 0);
        chk("t3_lh_busreq", s_busreq, 1'b0);
        access(1'b1, 3'b000, 32'h0000_3000, 32'h1, 0, 32'd0);
        chk("t3_sw_ades", s_ades, 1'b1);
        chk("t3_sw_adel", s_adel, 1'b0);
        access(1'b0, 3'b101, 32'h0000_0020, 32'd0, 0, 32'd0);
        chk("t3_badop_adel", s_adel, 1'b1);
        access(1'b0, 3'b000, 32'h0000_2FFC, 32'd0, 0, 32'h0BAD_CAFE);
        chk("t3_edge_resps", resps, 1);
        chk("t3_edge_rdata", s_rd, 32'h0BAD_CAFE);

        // 4: lbu with 3 wait cycles
        access(1'b0, 3'b001, 32'h0000_0022, 32'd0, 3, 32'h8899_AABB);
        chk("t4_stalls", stalls, 5);
        chk("t4_resps", resps, 1);
        chk("t4_a", s_a, 2'b10);
        chk("t4_op", s_op, 3'b001);
        chk("t4_bus_addr", bus_addr, 32'h0000_0020);

        // 5: reset during the second BUSY cycle
        req_valid = 1'b1; req_we = 1'b0; req_op = 3'b000; req_addr = 32'h0000_0040;
        @(negedge clk);               // accept
        @(negedge clk); bus_ready = 1'b0;  // BUSY 1
        @(negedge clk);               // BUSY 2
        reset = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t5_stall", stall, 0);
        chk("t5_bus_req", bus_req, 0);
        chk("t5_bus_addr", bus_addr, 0);
        chk("t5_bus_be", bus_be, 0);
        chk("t5_resp_valid", resp_valid, 0);
        chk("t5_resp_rdata", resp_rdata, 0);
        resps = 0;
        bus_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) resps++;
        end
        bus_ready = 1'b0;
        chk("t5_no_resp", resps, 0);
        @(posedge clk); #1;

        // 6: back-to-back lw then sw; lh sign op passes through
        access(1'b0, 3'b000, 32'h0000_0080, 32'd0, 0, 32'h1111_2222);
        chk("t6_lw_resps", resps, 1);
        chk("t6_lw_rdata", s_rd, 32'h1111_2222);
        access(1'b1, 3'b000, 32'h0000_0084, 32'hCAFE_F00D, 1, 32'h7777_7777);
        chk("t6_sw_first_stall", s_first_stall, 1'b1);
        chk("t6_sw_stalls", stalls, 3);
        chk("t6_sw_resps", resps, 1);
        chk("t6_sw_wd", s_wd, 32'hCAFE_F00D);
        chk("t6_sw_rdata", s_rd, 32'd0);
        access(1'b0, 3'b100, 32'h0000_0012, 32'd0, 0, 32'h8000_ABCD);
        chk("t6_lh_a", s_a, 2'b10);
        chk("t6_lh_op", s_op, 3'b100);
        chk("t6_lh_rdata", s_rd, 32'h8000_ABCD);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
